// File: rtl/fetch_unit_if.sv
// Bundle of signals between the fetch unit, instruction memory, the
// downstream redirect source and the decode stage.
//   master : the fetch unit itself
//   slave  : the surrounding pipeline / memory
interface fetch_unit_if #(
    parameter int ADDR_W  = 32,
    parameter int INSTR_W = 32
);
    logic [ADDR_W-1:0]  address_imem;
    logic [INSTR_W-1:0] q_imem;
    logic               stall;
    logic               redirect_valid;
    logic [ADDR_W-1:0]  redirect_pc;
    logic [INSTR_W-1:0] ir_d;
    logic [ADDR_W-1:0]  pc_d;
    logic               valid_d;
    logic [31:0]        fetch_count;

    modport master (
        output address_imem,
        input  q_imem,
        input  stall,
        input  redirect_valid,
        input  redirect_pc,
        output ir_d,
        output pc_d,
        output valid_d,
        output fetch_count
    );

    modport slave (
        input  address_imem,
        output q_imem,
        output stall,
        output redirect_valid,
        output redirect_pc,
        input  ir_d,
        input  pc_d,
        input  valid_d,
        input  fetch_count
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: program counter plus the FD pipeline latch.
// Priority per edge: reset > redirect > stall > predecode jump > sequential.
// Optional feature: define FETCH_PREDECODE_EN to follow j/jal (opcode
// 00001 / 00011 in [31:27]) in the fetch stage without a bubble.
module fetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter int                INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic         clock,
    input  logic         reset,
    fetch_unit_if.master fif
);

    logic [ADDR_W-1:0]  pc_f_q,     pc_f_d;
    logic [INSTR_W-1:0] fd_ir_q,    fd_ir_d;
    logic [ADDR_W-1:0]  fd_pc_q,    fd_pc_d;
    logic               fd_valid_q, fd_valid_d;
    logic [31:0]        count_q,    count_d;
    logic [ADDR_W-1:0]  pc_inc;

    // Wraps modulo 2^ADDR_W; the FD link value uses the same wrapped result.
    assign pc_inc = pc_f_q + ADDR_W'(1);

`ifdef FETCH_PREDECODE_EN
    logic [ADDR_W-1:0] jump_target;
    logic              is_jump;

    assign is_jump = (fif.q_imem[31:27] == 5'b00001) || (fif.q_imem[31:27] == 5'b00011);

    // Jump target field [26:0], zero-extended or truncated to the PC width.
    always_comb begin
        jump_target = '0;
        for (int i = 0; i < ADDR_W && i < 27; i++) begin
            jump_target[i] = fif.q_imem[i];
        end
    end
`endif

    // Next-state selection: redirect squashes FD, stall holds everything,
    // otherwise the current imem word is accepted into FD.
    always_comb begin
        pc_f_d     = pc_f_q;
        fd_ir_d    = fd_ir_q;
        fd_pc_d    = fd_pc_q;
        fd_valid_d = fd_valid_q;
        count_d    = count_q;
        if (fif.redirect_valid) begin
            pc_f_d     = fif.redirect_pc;
            fd_ir_d    = '0;
            fd_pc_d    = '0;
            fd_valid_d = 1'b0;
        end else if (!fif.stall) begin
            pc_f_d     = pc_inc;
            fd_ir_d    = fif.q_imem;
            fd_pc_d    = pc_inc;
            fd_valid_d = 1'b1;
            count_d    = count_q + 32'd1;
`ifdef FETCH_PREDECODE_EN
            // The jump itself still enters FD with its link value.
            if (is_jump) begin
                pc_f_d = jump_target;
            end
`endif
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_f_q     <= RESET_PC;
            fd_ir_q    <= '0;
            fd_pc_q    <= '0;
            fd_valid_q <= 1'b0;
            count_q    <= '0;
        end else begin
            pc_f_q     <= pc_f_d;
            fd_ir_q    <= fd_ir_d;
            fd_pc_q    <= fd_pc_d;
            fd_valid_q <= fd_valid_d;
            count_q    <= count_d;
        end
    end

    assign fif.address_imem = pc_f_q;
    assign fif.ir_d         = fd_ir_q;
    assign fif.pc_d         = fd_pc_q;
    assign fif.valid_d      = fd_valid_q;
    assign fif.fetch_count  = count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: sequential fetch, stall, redirect (also
// under stall), consecutive redirects, async reset, j/jal handling and
// 8-bit PC wrap-around on a second instance.
module tb_fetch_unit;

    localparam logic [31:0] JAL_WORD = {5'b00011, 27'd50};

    logic clk = 1'b0;
    logic rst;
    logic rst8;
    logic jal_mode = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    fetch_unit_if #(.ADDR_W(32), .INSTR_W(32)) fif ();
    fetch_unit_if #(.ADDR_W(8),  .INSTR_W(32)) fif8 ();

    // Instruction memory models: word n = n + 100 (word 3 optionally a jal).
    assign fif.q_imem  = (jal_mode && fif.address_imem == 32'd3) ? JAL_WORD
                                                                 : fif.address_imem + 32'd100;
    assign fif8.q_imem = {24'd0, fif8.address_imem} + 32'd100;

    fetch_unit #(.ADDR_W(32), .INSTR_W(32), .RESET_PC(32'd0)) dut (
        .clock (clk),
        .reset (rst),
        .fif   (fif)
    );

    fetch_unit #(.ADDR_W(8), .INSTR_W(32), .RESET_PC(8'hFE)) dut8 (
        .clock (clk),
        .reset (rst8),
        .fif   (fif8)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %-18s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_fd(input string tag, input logic [31:0] ir, input logic [31:0] pcd,
                            input logic vld);
        check({tag, ".ir"},    fif.ir_d,    ir);
        check({tag, ".pc_d"},  fif.pc_d,    pcd);
        check({tag, ".valid"}, {31'd0, fif.valid_d}, {31'd0, vld});
    endtask

    initial begin
        rst  = 1'b1;
        rst8 = 1'b1;
        fif.stall           = 1'b0;
        fif.redirect_valid  = 1'b0;
        fif.redirect_pc     = '0;
        fif8.stall          = 1'b0;
        fif8.redirect_valid = 1'b0;
        fif8.redirect_pc    = '0;
        #1;
        check("rst.addr",  fif.address_imem, 32'd0);
        check_fd("rst", 32'd0, 32'd0, 1'b0);
        check("rst.count", fif.fetch_count, 32'd0);
        check("rst8.addr", {24'd0, fif8.address_imem}, 32'hFE);

        // Sequential fetch from reset.
        @(negedge clk);
        rst = 1'b0;
        step(); check_fd("seq1", 32'd100, 32'd1, 1'b1);
        step(); check_fd("seq2", 32'd101, 32'd2, 1'b1);
        step(); check_fd("seq3", 32'd102, 32'd3, 1'b1);
        step(); check_fd("seq4", 32'd103, 32'd4, 1'b1);
        check("seq4.count", fif.fetch_count, 32'd4);
        step();
        check("pre_stall.addr", fif.address_imem, 32'd5);
        check("pre_stall.count", fif.fetch_count, 32'd5);

        // Stall three cycles at PC=5.
        fif.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall.addr",  fif.address_imem, 32'd5);
            check_fd("stall", 32'd104, 32'd5, 1'b1);
            check("stall.count", fif.fetch_count, 32'd5);
        end
        fif.stall = 1'b0;
        step(); check_fd("resume1", 32'd105, 32'd6, 1'b1);
        step(); check_fd("resume2", 32'd106, 32'd7, 1'b1);
        check("resume2.addr",  fif.address_imem, 32'd7);
        check("resume2.count", fif.fetch_count, 32'd7);

        // Redirect with simultaneous stall at PC=7.
        fif.redirect_valid = 1'b1;
        fif.stall          = 1'b1;
        fif.redirect_pc    = 32'd40;
        step();
        fif.redirect_valid = 1'b0;
        fif.stall          = 1'b0;
        check("redir.addr",  fif.address_imem, 32'd40);
        check_fd("redir", 32'd0, 32'd0, 1'b0);
        check("redir.count", fif.fetch_count, 32'd7);
        step(); check_fd("redir_tgt", 32'd140, 32'd41, 1'b1);
        check("redir_tgt.count", fif.fetch_count, 32'd8);

        // Consecutive redirects: the last one wins.
        fif.redirect_valid = 1'b1;
        fif.redirect_pc    = 32'd60;
        step();
        fif.redirect_pc    = 32'd70;
        step();
        fif.redirect_valid = 1'b0;
        check("redir2.addr", fif.address_imem, 32'd70);
        check_fd("redir2", 32'd0, 32'd0, 1'b0);
        step(); check_fd("redir2_tgt", 32'd170, 32'd71, 1'b1);

        // Asynchronous reset between edges while at PC=20.
        fif.redirect_valid = 1'b1;
        fif.redirect_pc    = 32'd19;
        step();
        fif.redirect_valid = 1'b0;
        step();
        check("pre_rst.addr", fif.address_imem, 32'd20);
        check_fd("pre_rst", 32'd119, 32'd20, 1'b1);
        #1 rst = 1'b1;
        #1;
        check("arst.addr",  fif.address_imem, 32'd0);
        check_fd("arst", 32'd0, 32'd0, 1'b0);
        check("arst.count", fif.fetch_count, 32'd0);
        #1 rst = 1'b0;
        step(); check_fd("post_rst", 32'd100, 32'd1, 1'b1);
        check("post_rst.count", fif.fetch_count, 32'd1);

        // Jump handling: word 3 is a jal to 50.
        jal_mode           = 1'b1;
        fif.redirect_valid = 1'b1;
        fif.redirect_pc    = 32'd3;
        step();
        fif.redirect_valid = 1'b0;
        check("jal.addr0", fif.address_imem, 32'd3);
        step();
        check_fd("jal", JAL_WORD, 32'd4, 1'b1);
`ifdef FETCH_PREDECODE_EN
        check("jal.addr1", fif.address_imem, 32'd50);
        step(); check_fd("jal_tgt", 32'd150, 32'd51, 1'b1);
`else
        check("jal.addr1", fif.address_imem, 32'd4);
        step(); check_fd("jal_next", 32'd104, 32'd5, 1'b1);
`endif
        jal_mode = 1'b0;

        // 8-bit PC wrap-around from FE.
        rst8 = 1'b0;
        check("wrap.addr0", {24'd0, fif8.address_imem}, 32'hFE);
        step();
        check("wrap.addr1", {24'd0, fif8.address_imem}, 32'hFF);
        check("wrap.pcd1",  {24'd0, fif8.pc_d}, 32'hFF);
        check("wrap.ir1",   fif8.ir_d, 32'd354);
        step();
        check("wrap.addr2", {24'd0, fif8.address_imem}, 32'h00);
        check("wrap.pcd2",  {24'd0, fif8.pc_d}, 32'h00);
        check("wrap.ir2",   fif8.ir_d, 32'd355);
        step();
        check("wrap.addr3", {24'd0, fif8.address_imem}, 32'h01);
        check("wrap.pcd3",  {24'd0, fif8.pc_d}, 32'h01);
        check("wrap.ir3",   fif8.ir_d, 32'd100);
        check("wrap.count", fif8.fetch_count, 32'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Parametrised instruction-fetch front end for the five-stage pipeline. It replaces the free-running program counter and the bare FD latch with one block that adds:
- stall (hold)
- redirect from a later stage (branch/jump resolved downstream), with squash of the FD slot
- a valid bit travelling with the fetched instruction

Sits between imem and the decode stage. It drives `address_imem` and presents `ir_d`/`pc_d`/`valid_d` to decode.

## Interface
Parameters:
- `ADDR_W`, 32, width of PC and instruction address.
- `INSTR_W`, 32, instruction width (must be ≥ 32; opcode is `[31:27]`).
- `RESET_PC`, 0, PC value loaded by reset.

Ports:
- `clock`  in  1  master clock, all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `address_imem`  out  ADDR_W  current PC (`pc_f`), combinational from PC register.
- `q_imem`  in  INSTR_W  instruction at `address_imem`, valid in the same cycle.
- `stall`  in  1  hold PC and FD contents this cycle.
- `redirect_valid`  in  1  downstream control transfer taken this cycle.
- `redirect_pc`  in  ADDR_W  target PC when `redirect_valid`=1.
- `ir_d`  out  INSTR_W  FD instruction register.
- `pc_d`  out  ADDR_W  FD PC register, holds address of fetched instruction + 1.
- `valid_d`  out  1  FD slot holds a real instruction.
- `fetch_count`  out  32  number of instructions accepted into FD since reset.

## Operation
Per-edge priority: reset > redirect > stall > predecode jump (if compiled in) > sequential.

- **Reset (async):**
  - PC = `RESET_PC`
  - `ir_d` = 0 (NOP)
  - `pc_d` = 0
  - `valid_d` = 0
  - `fetch_count` = 0
- **Redirect** (`redirect_valid`=1, regardless of `stall`):
  - PC ← `redirect_pc`.
  - FD squashed: `ir_d` ← 0, `valid_d` ← 0, `pc_d` ← 0.
  - `fetch_count` unchanged.
- **Stall** (`stall`=1, no redirect):
  - PC, `ir_d`, `pc_d`, `valid_d` and `fetch_count` all hold.
- **Sequential:**
  - PC ← PC+1 (mod 2^ADDR_W).
  - `ir_d` ← `q_imem`, `pc_d` ← PC+1, `valid_d` ← 1.
  - `fetch_count` ← `fetch_count`+1 (wraps at 2^32).
- **Arithmetic:**
  - PC increment is unsigned, modulo 2^ADDR_W; PC = all-ones wraps to 0.
  - `pc_d` uses the same wrapped value.
- **NOP encoding:** all-zeros instruction. Decode must treat `valid_d`=0 as a bubble regardless of `ir_d`.

## Timing
- **Fetch latency:**
  - Instruction at PC=n appears on `ir_d` one edge after n is on `address_imem`, given no stall or redirect.
- **Redirect penalty:**
  - Edge k samples `redirect_valid`.
  - `address_imem` = `redirect_pc` during cycle k+1.
  - The target instruction is on `ir_d` after edge k+1.
  - Exactly one invalid FD cycle follows the redirect edge; the instruction fetched in the redirect cycle is discarded.
- **Stall:**
  - `address_imem` is stable for the whole stalled cycle.
  - Deasserting `stall` resumes with no lost or duplicated instruction.
- **Redirect during stall:**
  - Redirect wins: PC loads the target and FD is squashed.
  - The stalled instruction is dropped (the downstream stage owns that decision).
- **Consecutive redirects:** each edge with `redirect_valid` reloads PC; the last one wins.
- **Reset mid-operation:**
  - Outputs go to reset values asynchronously.
  - First fetch from `RESET_PC` is latched at the first rising edge after `reset` deasserts.

## Configuration
Macro `FETCH_PREDECODE_EN`:
- **Defined:**
  - A predecoder examines `q_imem[31:27]` in the sequential case. Opcode `00001` (j) or `00011` (jal) loads PC ← `q_imem[26:0]`, zero-extended or truncated to `ADDR_W`.
  - The jump itself is still latched into FD normally (`pc_d` = its address+1, `valid_d`=1), so jal links correctly and no bubble is inserted.
  - Stall and redirect still take priority over the predecode jump.
- **Undefined:** no predecode; j/jal fetch sequentially and must be resolved via `redirect_valid` (one bubble each).

## Test plan
- **Reset and sequential fetch:**
  - Stimulus: `RESET_PC`=0, imem word n = n+100, reset then 4 edges.
  - Required: `ir_d` = 100, 101, 102, 103; `pc_d` = 1, 2, 3, 4; `valid_d`=1; `fetch_count`=4.
- **Stall:**
  - Stimulus: `stall` high for 3 cycles at PC=5.
  - Required: `address_imem` stays 5; `ir_d`/`pc_d` hold; `fetch_count` unchanged.
  - After release: `ir_d` = word 5, then word 6.
- **Redirect with simultaneous stall:**
  - Stimulus: at PC=7 assert `redirect_valid`=1 and `stall`=1 with `redirect_pc`=40.
  - Required: next cycle `address_imem`=40, `valid_d`=0, `ir_d`=0; following edge `ir_d` = word 40, `pc_d`=41.
- **Wrap-around:**
  - Stimulus: `ADDR_W`=8, `RESET_PC`=8'hFE, 3 edges.
  - Required: `address_imem` = FE, FF, 00, 01; `pc_d` after FF fetch = 00.
- **Async reset mid-run:**
  - Stimulus: pulse `reset` between edges at PC=20.
  - Required: outputs reset immediately, without waiting for an edge; `address_imem`=`RESET_PC`; `fetch_count`=0.
- **Predecode (macro defined):**
  - Stimulus: word 3 = jal target 50.
  - Required: `address_imem` = 3 then 50; `ir_d` = jal with `pc_d`=4 and `valid_d`=1, followed directly by word 50.
  - With macro undefined: `address_imem` = 4 after 3.
